// File: rtl/div_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg
//   Shared definitions for the sequential divider and its arithmetic siblings.
//   - DIV_WIDTH : default operand width, also used by the multiplier
//   - S_IDLE / S_RUN / S_DONE : FSM state encodings
//   - div_state_e : typed view of those encodings for the divider FSM
// ----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_WIDTH = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } div_state_e;

endpackage

// File: rtl/cla_adder.sv
// ----------------------------------------------------------------------------
// cla_adder
//   Combinational carry-lookahead adder: o_sum = i_a + i_b + i_cin (mod 2^WIDTH).
//   Every carry is a flat sum-of-products of generate/propagate terms instead of
//   a rippled chain.
//   Ports:
//     i_a, i_b  [WIDTH-1:0]  addends
//     i_cin                  carry in
//     o_sum     [WIDTH-1:0]  sum (carry out is not produced)
// ----------------------------------------------------------------------------
module cla_adder
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum
);

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Carry into bit n: OR over k<n of g[k] & p[k+1..n-1], plus cin & p[0..n-1].
  function automatic logic lookahead_carry(
    input logic [WIDTH-1:0] g,
    input logic [WIDTH-1:0] p,
    input logic             cin,
    input int               n
  );
    logic c;
    logic pp;
    // NOTE: blocking assignments here are intentional; this is pure combinational
    // evaluation and each statement must see the previous one's result.
    c  = 1'b0;
    pp = 1'b1;
    for (int k = n - 1; k >= 0; k--) begin
      c  = c | (g[k] & pp);
      pp = pp & p[k];
    end
    return c | (cin & pp);
  endfunction

  for (genvar i = 0; i < WIDTH; i++) begin : g_carry
    assign w_c[i] = lookahead_carry(w_g, w_p, i_cin, i);
  end

  assign o_sum = w_p ^ w_c;

endmodule

// File: rtl/div_step.sv
// ----------------------------------------------------------------------------
// div_step
//   One restoring-division step (combinational).
//     S = {R, q_msb};  T = S - {0, D}
//     T >= 0 : next R = T, quotient bit 1
//     T <  0 : next R = S, quotient bit 0
//   The subtract is the CLA adder fed with ~{0,D} and carry-in 1.
//   Ports:
//     i_r      [WIDTH-1:0]  current partial remainder (always < D)
//     i_q_msb               dividend bit shifted in this step
//     i_d      [WIDTH-1:0]  divisor
//     o_r      [WIDTH-1:0]  next partial remainder
//     o_q_bit               quotient bit produced by this step
// ----------------------------------------------------------------------------
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_r,
  input  logic             i_q_msb,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_r,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_s;
  logic [WIDTH:0] w_d_n;
  logic [WIDTH:0] w_t;

  assign w_s   = {i_r, i_q_msb};
  assign w_d_n = ~{1'b0, i_d};

  cla_adder #(.WIDTH(WIDTH + 1)) u_sub (
    .i_a   (w_s),
    .i_b   (w_d_n),
    .i_cin (1'b1),
    .o_sum (w_t)
  );

  // Because R < D, S < 2D: a successful subtract leaves T < D < 2^WIDTH and a
  // failed one keeps S < D, so the next remainder always fits in WIDTH bits and
  // the WIDTH+1-bit remainder's top bit never needs storing.
  assign o_q_bit = ~w_t[WIDTH];
  assign o_r     = o_q_bit ? w_t[WIDTH-1:0] : w_s[WIDTH-1:0];

endmodule

// File: rtl/seq_div8.sv
// ----------------------------------------------------------------------------
// seq_div8
//   Sequential restoring divider, one quotient bit per clock.
//   unsigned dividend / divisor -> quotient, remainder; divisor==0 flagged.
//   Ports:
//     clk          rising-edge clock
//     rst          synchronous active-high reset (wins over start)
//     start        request; accepted only in IDLE or DONE
//     dividend     numerator, sampled with an accepted start
//     divisor      denominator, sampled with an accepted start
//     busy         high while stepping (RUN)
//     done         one-cycle pulse in DONE
//     quotient     result, valid from done until the next accepted start
//     remainder    result, same validity as quotient
//     div_by_zero  set with done when the latched divisor was zero
// ----------------------------------------------------------------------------
module seq_div8
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  div_state_e       r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_d;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;

  logic [WIDTH-1:0] w_next_r;
  logic             w_q_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_r     (r_r),
    .i_q_msb (r_q[WIDTH-1]),
    .i_d     (r_d),
    .o_r     (w_next_r),
    .o_q_bit (w_q_bit)
  );

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values, exactly like the hardware flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_d     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_count <= CW'(WIDTH - 1);
            r_d     <= divisor;
            if (divisor == '0) begin
              // Short-circuit: report all-ones quotient, dividend as remainder.
              r_q     <= '1;
              r_r     <= dividend;
              r_dbz   <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_q     <= dividend;
              r_r     <= '0;
              r_dbz   <= 1'b0;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_state <= ST_RUN;
            end
          end else begin
            // Results and flag stay visible in IDLE; only the pulse drops.
            r_done  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        ST_RUN: begin
          r_r <= w_next_r;
          r_q <= {r_q[WIDTH-2:0], w_q_bit};
          if (r_count == '0) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_q;
  assign remainder   = r_r;
  assign div_by_zero = r_dbz;

endmodule
